// File: rtl/alu_issue_unit.sv
// Issue stage for the 4-bit ALU: request FIFO, IDLE/ISSUE/HOLD sequencer, registered result handshake.
// Optional macro ALU_ILLEGAL_OP_CHECK_EN flags sel[2:0] in {110,111} as illegal and forces a zero result.
module alu_issue_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 5,
  parameter int RES_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_zero,
  output logic              res_carry,
  output logic [SEL_W-1:0]  res_sel,
  output logic              res_err,
  output logic              busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  req_t              r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_alu_a, r_alu_b;
  logic [SEL_W-1:0]  r_alu_sel, r_cur_sel;
  logic              r_cur_ill;
  logic [RES_W-1:0]  r_res_data;
  logic              r_res_zero, r_res_carry, r_res_err;
  logic [SEL_W-1:0]  r_res_sel;

  logic w_empty, w_full, w_push, w_pop, w_capture, w_head_ill;
  req_t w_head, w_in_req;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_in_req = '{a: in_a, b: in_b, sel: in_sel};

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  assign w_head_ill = (w_head.sel[2:1] == 2'b11);
`else
  assign w_head_ill = 1'b0;
`endif

  // FIFO storage needs no reset: validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_capture   = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: if (res_ready) begin
        w_pop       = !w_empty;
        w_state_nxt = w_empty ? IDLE : ISSUE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // An illegal op still occupies the ALU slot but presents opcode 0 to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_cur_sel <= '0;
      r_cur_ill <= 1'b0;
    end else if (w_pop) begin
      r_alu_a   <= w_head.a;
      r_alu_b   <= w_head.b;
      r_alu_sel <= w_head_ill ? '0 : w_head.sel;
      r_cur_sel <= w_head.sel;
      r_cur_ill <= w_head_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
      r_res_carry <= 1'b0;
      r_res_sel   <= '0;
      r_res_err   <= 1'b0;
    end else if (w_capture) begin
      r_res_data  <= r_cur_ill ? '0 : alu_out;
      r_res_zero  <= !r_cur_ill && alu_zero;
      r_res_carry <= !r_cur_ill && alu_carry;
      r_res_sel   <= r_cur_sel;
      r_res_err   <= r_cur_ill;
    end
  end

  assign in_ready  = !w_full;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_valid = (r_state == HOLD);
  assign res_data  = r_res_data;
  assign res_zero  = r_res_zero;
  assign res_carry = r_res_carry;
  assign res_sel   = r_res_sel;
  assign res_err   = r_res_err;
  assign busy      = !w_empty || (r_state != IDLE);
endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU and an outstanding-request scoreboard.
module tb_alu_issue_unit;
  localparam int DEPTH = 4, DATA_W = 4, SEL_W = 5, RES_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_a, in_b, alu_a, alu_b;
  logic [SEL_W-1:0]  in_sel, alu_sel, res_sel;
  logic [RES_W-1:0]  alu_out, res_data;
  logic              alu_zero, alu_carry;
  logic              res_valid, res_ready, res_zero, res_carry, res_err, busy;

  typedef struct packed {
    logic             err;
    logic [SEL_W-1:0] sel;
    logic             zero;
    logic             carry;
    logic [RES_W-1:0] data;
  } res_t;

  int   n_tests = 0, n_fail = 0, cyc = 0;
  res_t obs_q[$];
  int   obs_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .res_carry(res_carry), .res_sel(res_sel), .res_err(res_err), .busy(busy)
  );

  // Stand-in 4-bit ALU; carry is bit 4 of the widened result.
  function automatic logic [RES_W-1:0] alu_fn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                              input logic [SEL_W-1:0] sel);
    logic [RES_W-1:0] ea, eb;
    ea = RES_W'(a);
    eb = RES_W'(b);
    case (sel[2:0])
      3'd0:    return ea + eb;
      3'd1:    return ea - eb;
      3'd2:    return ea * eb;
      3'd3:    return ea & eb;
      3'd4:    return ea | eb;
      3'd5:    return ea ^ eb;
      3'd6:    return ea << 1;
      default: return RES_W'(~(a | b));
    endcase
  endfunction

  assign alu_out   = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_zero  = (alu_out == '0);
  assign alu_carry = alu_out[4];

  function automatic res_t expect_of(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                     input logic [SEL_W-1:0] sel);
    res_t r;
    logic ill;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    ill = (sel[2:0] == 3'b110) || (sel[2:0] == 3'b111);
`else
    ill = 1'b0;
`endif
    r.sel = sel;
    r.err = ill;
    r.data = ill ? '0 : alu_fn(a, b, sel);
    r.zero = !ill && (r.data == '0);
    r.carry = !ill && r.data[4];
    return r;
  endfunction

  function automatic res_t observed();
    return '{err: res_err, sel: res_sel, zero: res_zero, carry: res_carry, data: res_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [SEL_W-1:0] sel);
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel;
  endtask

  // Accepts results with res_ready high until n are seen or the cycle budget expires.
  task automatic drain(input int n, input int max_cyc);
    obs_q.delete();
    obs_cyc.delete();
    res_ready = 1'b1;
    for (int c = 0; c < max_cyc && obs_q.size() < n; c++) begin
      if (res_valid) begin
        obs_q.push_back(observed());
        obs_cyc.push_back(cyc);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0;
    #2;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if ({alu_a, alu_b, alu_sel} !== '0) begin n_fail++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_sel}); end
    n_tests++; if (observed() !== res_t'(0)) begin n_fail++; $display("FAIL reset_res: got %h want 0", observed()); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    res_ready = 1'b1;
    set_req(4'd5, 4'd3, 5'd0);
    tick();
    in_valid = 1'b0;
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_n1: got %b want 0", res_valid); end
    tick();
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_n2: got %b want 0", res_valid); end
    n_tests++; if ({alu_a, alu_b, alu_sel} !== {4'd5, 4'd3, 5'd0}) begin n_fail++; $display("FAIL t1_alu_in: got %h want %h", {alu_a, alu_b, alu_sel}, {4'd5, 4'd3, 5'd0}); end
    tick();
    n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL t1_latency: got %b want 1", res_valid); end
    n_tests++; if (res_data !== 8'd8 || res_zero !== 1'b0 || res_sel !== 5'd0) begin n_fail++; $display("FAIL t1_result: got data %0d zero %b sel %h want 8 0 00", res_data, res_zero, res_sel); end
    tick();
    n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle: got valid %b busy %b want 0 0", res_valid, busy); end
    // T2: zero flag and ordering
    res_ready = 1'b0;
    set_req(4'd4, 4'd4, 5'd1); tick();
    set_req(4'd7, 4'd2, 5'd2); tick();
    in_valid = 1'b0;
    drain(2, 20);
    n_tests++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL t2_count: got %0d want 2", obs_q.size()); end
    else begin
      n_tests++; if (obs_q[0].data !== 8'd0 || obs_q[0].zero !== 1'b1) begin n_fail++; $display("FAIL t2_zero: got data %0d zero %b want 0 1", obs_q[0].data, obs_q[0].zero); end
      n_tests++; if (obs_q[1].data !== 8'd14 || obs_q[1].sel !== 5'd2) begin n_fail++; $display("FAIL t2_mul: got data %0d sel %h want 14 02", obs_q[1].data, obs_q[1].sel); end
    end
  endtask

  task automatic test_backpressure();
    res_t exp_q[$];
    logic rdy_seen[6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(DATA_W'(i + 1), DATA_W'(2 * i), SEL_W'(i % 6));
      rdy_seen[i] = in_ready;
      if (in_ready) exp_q.push_back(expect_of(in_a, in_b, in_sel));
      tick();
    end
    in_valid = 1'b0;
    n_tests++; if (exp_q.size() !== 5) begin n_fail++; $display("FAIL t3_accepted: got %0d want 5", exp_q.size()); end
    n_tests++; if (rdy_seen[4] !== 1'b1 || rdy_seen[5] !== 1'b0) begin n_fail++; $display("FAIL t3_in_ready: got 5th %b 6th %b want 1 0", rdy_seen[4], rdy_seen[5]); end
    drain(5, 40);
    n_tests++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL t3_results: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t3_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_tests++; if (obs_cyc[i] - obs_cyc[i-1] !== 2) begin n_fail++; $display("FAIL t3_rate[%0d]: got %0d cycles want 2", i, obs_cyc[i] - obs_cyc[i-1]); end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy: got %b want 0", busy); end
  endtask

  task automatic test_illegal();
    res_t exp;
    do_reset();
    set_req(4'd5, 4'd3, 5'b00110);
    exp = expect_of(4'd5, 4'd3, 5'b00110);
    tick();
    in_valid = 1'b0;
    drain(1, 10);
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL t4_count: got %0d want 1", obs_q.size()); end
    else begin
      n_tests++; if (obs_q[0] !== exp) begin n_fail++; $display("FAIL t4_result: got %h want %h", obs_q[0], exp); end
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      n_tests++; if (obs_q[0].err !== 1'b1 || obs_q[0].data !== 8'd0) begin n_fail++; $display("FAIL t4_err: got err %b data %0d want 1 0", obs_q[0].err, obs_q[0].data); end
      n_tests++; if (alu_sel !== 5'd0) begin n_fail++; $display("FAIL t4_alu_sel: got %h want 00", alu_sel); end
`else
      n_tests++; if (obs_q[0].err !== 1'b0 || obs_q[0].data !== 8'd10) begin n_fail++; $display("FAIL t4_err: got err %b data %0d want 0 10", obs_q[0].err, obs_q[0].data); end
      n_tests++; if (alu_sel !== 5'b00110) begin n_fail++; $display("FAIL t4_alu_sel: got %h want 06", alu_sel); end
`endif
    end
  endtask

  task automatic test_reset_in_hold();
    int stale;
    do_reset();
    for (int i = 0; i < 4; i++) begin set_req(DATA_W'(i + 9), DATA_W'(i), 5'd0); tick(); end
    in_valid = 1'b0;
    n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL t5_hold: got %b want 1", res_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL t5_async: got valid %b ready %b busy %b want 0 1 0", res_valid, in_ready, busy); end
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (res_valid || busy) stale++; end
    n_tests++; if (stale !== 0) begin n_fail++; $display("FAIL t5_stale: got %0d active cycles want 0", stale); end
  endtask

  task automatic test_push_pop_full();
    res_t exp_q[$];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(DATA_W'(3 * i + 1), DATA_W'(i + 2), SEL_W'(i));
      exp_q.push_back(expect_of(in_a, in_b, in_sel));
      tick();
    end
    n_tests++; if (res_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL t6_setup: got valid %b ready %b want 1 1", res_valid, in_ready); end
    set_req(4'd15, 4'd15, 5'd2);
    exp_q.push_back(expect_of(4'd15, 4'd15, 5'd2));
    res_ready = 1'b1;
    obs_q.delete();
    obs_q.push_back(observed());
    tick();
    in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t6_count: got in_ready %b want 1", in_ready); end
    begin
      res_t first;
      first = obs_q[0];
      drain(4, 30);
      obs_q.push_front(first);
    end
    n_tests++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL t6_results: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t6_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tick();
    n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t6_dup: got valid %b busy %b want 0 0", res_valid, busy); end
  endtask

  task automatic test_random();
    res_t exp_q[$];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c < 300) set_req(DATA_W'($urandom), DATA_W'($urandom), SEL_W'($urandom));
      if (c >= 300 || $urandom_range(0, 2) == 0) in_valid = 1'b0;
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++; if (busy !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b outstanding %0d", c, busy, exp_q.size()); end
      if (exp_q.size() < DEPTH) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want 1 (outstanding %0d)", c, in_ready, exp_q.size()); end
      end
      if (exp_q.size() > DEPTH + 1) begin
        n_tests++; n_fail++; $display("FAIL rnd_capacity@%0d: got %0d outstanding want <= %0d", c, exp_q.size(), DEPTH + 1);
      end
      if (res_valid && res_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious@%0d: got %h want none", c, observed()); end
        else begin
          res_t e;
          e = exp_q.pop_front();
          if (observed() !== e) begin n_fail++; $display("FAIL rnd_result@%0d: got %h want %h", c, observed(), e); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(expect_of(in_a, in_b, in_sel));
      tick();
    end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rnd_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_reset_in_hold();
    test_push_pop_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
